// File: rtl/analog_status_monitor_if.sv
// APB bus bundle for analog_status_monitor.
// The master modport drives the request signals: PADDR, PSEL, PENABLE, PWRITE, PSTRB and PWDATA.
// The slave modport drives the response signals: PRDATA, PREADY and PSLVERR.
interface analog_status_monitor_if;
  logic [11:0] PADDR;
  logic        PENABLE;
  logic        PSEL;
  logic [3:0]  PSTRB;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PADDR, PENABLE, PSEL, PSTRB, PWDATA, PWRITE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PENABLE, PSEL, PSTRB, PWDATA, PWRITE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/analog_status_monitor.sv
// analog_status_monitor
//
// Purpose:
//   - Synchronises N_STATUS asynchronous analog status words into the clk_in domain.
//   - Exposes the words read-only over APB.
//   - Keeps per-channel sticky change flags, which are cleared by writing 1.
//   - Drives a maskable, registered level interrupt.
//   - Provides an atomic snapshot (shadow) of all channels.
//
// Ports:
//   clk_in     system clock
//   reset_n    synchronous active-low reset
//   apb        APB slave (PADDR/PSEL/PENABLE/PWRITE/PSTRB/PWDATA in, PRDATA/PREADY/PSLVERR out)
//   status_in  channel i at [i*STATUS_WIDTH +: STATUS_WIDTH], asynchronous to clk_in
//   irq        |(changed & mask), registered
//
// Register map (PADDR[1:0] must be 0):
//   0x000+4*i  STATUS_i  RO
//   0x100      CHANGED   W1C
//   0x104      IRQ_MASK  RW
//   0x108      SNAP      WO; reads return 0
//   0x200+4*i  SHADOW_i  RO
module analog_status_monitor #(
  parameter int N_STATUS     = 4,
  parameter int STATUS_WIDTH = 32,
  parameter int SYNC_DEPTH   = 2
) (
  input  logic                             clk_in,
  input  logic                             reset_n,
  analog_status_monitor_if.slave           apb,
  input  logic [N_STATUS*STATUS_WIDTH-1:0] status_in,
  output logic                             irq
);

  localparam int              VW        = N_STATUS * STATUS_WIDTH;
  localparam int              WARM_MAX  = SYNC_DEPTH + 1;
  localparam int              CW        = $clog2(WARM_MAX + 1);
  localparam logic [CW-1:0]   WARM_DONE = CW'(WARM_MAX);
  localparam logic [5:0]      N_IDX     = 6'(N_STATUS);

  logic [VW-1:0]       sync_q [SYNC_DEPTH];
  logic [VW-1:0]       status_q;
  logic [VW-1:0]       shadow_q;
  logic [N_STATUS-1:0] changed_q;
  logic [N_STATUS-1:0] mask_q;
  logic [CW-1:0]       warm_q;

  // status_nxt is the value status_q takes on the coming edge.
  // Reads of STATUS_i use it, so a response issued on the update edge already carries the new value.
  logic [VW-1:0]       status_nxt;
  logic [N_STATUS-1:0] diff;
  logic [N_STATUS-1:0] set_flags;
  logic [N_STATUS-1:0] w1c;

  logic        accept;
  logic [5:0]  widx;
  logic        in_status, in_shadow, is_changed, is_mask, is_snap;
  logic        mapped, read_only, err;
  logic [31:0] rd_data;
  logic        unused_pwdata;

  assign status_nxt    = sync_q[SYNC_DEPTH-1];
  assign unused_pwdata = ^apb.PWDATA[31:N_STATUS];

  // Handshake:
  //   - A transfer is accepted on the edge where PSEL & PENABLE & ~PREADY.
  //   - That edge raises PREADY for exactly one cycle, with PRDATA/PSLVERR valid.
  //   - The following edge drops PREADY, so every transfer sees one wait state.
  //   - Back-to-back accepts are impossible.
  assign accept = apb.PSEL & apb.PENABLE & ~apb.PREADY;

  assign widx       = apb.PADDR[7:2];
  assign in_status  = (apb.PADDR[11:8] == 4'h0) && (widx < N_IDX);
  assign in_shadow  = (apb.PADDR[11:8] == 4'h2) && (widx < N_IDX);
  assign is_changed = (apb.PADDR[11:2] == 10'h040);
  assign is_mask    = (apb.PADDR[11:2] == 10'h041);
  assign is_snap    = (apb.PADDR[11:2] == 10'h042);
  assign mapped     = in_status | in_shadow | is_changed | is_mask | is_snap;
  assign read_only  = in_status | in_shadow;
  assign err        = (apb.PADDR[1:0] != 2'b00) | ~mapped |
                      (apb.PWRITE & read_only) |
                      (apb.PWRITE & (apb.PSTRB != 4'hF));

  always_comb begin
    diff = '0;
    for (int i = 0; i < N_STATUS; i++) begin
      diff[i] = |(status_nxt[i*STATUS_WIDTH +: STATUS_WIDTH] ^
                  status_q[i*STATUS_WIDTH +: STATUS_WIDTH]);
    end
  end

  // Until the chains have filled, the last stage differs from status_q only because of reset.
  // Flags are therefore ignored until the warm-up count saturates.
  assign set_flags = (warm_q == WARM_DONE) ? diff : '0;

  assign w1c = (accept && apb.PWRITE && !err && is_changed) ?
               apb.PWDATA[N_STATUS-1:0] : '0;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_STATUS; i++) begin
      if (widx == 6'(i)) begin
        if (in_status) rd_data[STATUS_WIDTH-1:0] = status_nxt[i*STATUS_WIDTH +: STATUS_WIDTH];
        if (in_shadow) rd_data[STATUS_WIDTH-1:0] = shadow_q[i*STATUS_WIDTH +: STATUS_WIDTH];
      end
    end
    if (is_changed) rd_data[N_STATUS-1:0] = changed_q;
    if (is_mask)    rd_data[N_STATUS-1:0] = mask_q;
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_DEPTH; s++) sync_q[s] <= '0;
      status_q    <= '0;
      shadow_q    <= '0;
      changed_q   <= '0;
      mask_q      <= '0;
      warm_q      <= '0;
      apb.PRDATA  <= '0;
      apb.PREADY  <= 1'b0;
      apb.PSLVERR <= 1'b0;
      irq         <= 1'b0;
    end else begin
      sync_q[0] <= status_in;
      for (int s = 1; s < SYNC_DEPTH; s++) sync_q[s] <= sync_q[s-1];
      status_q <= status_nxt;
      if (warm_q != WARM_DONE) warm_q <= warm_q + 1'b1;

      // A new change on the same edge as a clear keeps the flag set.
      changed_q <= (changed_q & ~w1c) | set_flags;
      irq       <= |(changed_q & mask_q);

      if (accept) begin
        apb.PREADY  <= 1'b1;
        apb.PSLVERR <= err;
        apb.PRDATA  <= (apb.PWRITE || err) ? 32'h0 : rd_data;
        if (apb.PWRITE && !err) begin
          if (is_mask) mask_q <= apb.PWDATA[N_STATUS-1:0];
          // Non-blocking capture takes status_q before this edge's update.
          if (is_snap && apb.PWDATA[0]) shadow_q <= status_q;
        end
      end else begin
        apb.PREADY  <= 1'b0;
        apb.PSLVERR <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_analog_status_monitor.sv
// Bench for analog_status_monitor.
// Instance a is the default 4x32 configuration.
// Instance b is a 3x10 configuration.
module tb_analog_status_monitor;

  localparam int SD = 2;

  logic clk = 1'b0;
  logic reset_n, reset_n_b;
  logic [127:0] status_a;
  logic [29:0]  status_b;
  logic irq_a, irq_b;

  analog_status_monitor_if bus_a ();
  analog_status_monitor_if bus_b ();

  analog_status_monitor #(.N_STATUS(4), .STATUS_WIDTH(32), .SYNC_DEPTH(SD)) dut_a (
    .clk_in(clk), .reset_n(reset_n), .apb(bus_a), .status_in(status_a), .irq(irq_a)
  );

  analog_status_monitor #(.N_STATUS(3), .STATUS_WIDTH(10), .SYNC_DEPTH(SD)) dut_b (
    .clk_in(clk), .reset_n(reset_n_b), .apb(bus_b), .status_in(status_b), .irq(irq_b)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  // Entry: {addr[11:0], check_data, pslverr, prdata[31:0]}
  logic [45:0] exp_a_q[$];
  logic [45:0] exp_b_q[$];

  // Reference model of instance a, with values as seen once the inputs have settled.
  logic [31:0] m_status [4];
  logic [31:0] m_shadow [4];
  logic [3:0]  m_changed;
  logic [3:0]  m_mask;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic monitor_step();
    logic [45:0] e;
    if (bus_a.PREADY === 1'b1) begin
      checks++;
      if (exp_a_q.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_pready actual prdata=%h pslverr=%b required=no response",
                 bus_a.PRDATA, bus_a.PSLVERR);
      end else begin
        e = exp_a_q.pop_front();
        if (bus_a.PSLVERR !== e[32] || (e[33] && bus_a.PRDATA !== e[31:0])) begin
          errors++;
          $display("FAIL a_resp addr=%h actual pslverr=%b prdata=%h expected pslverr=%b prdata=%h",
                   e[45:34], bus_a.PSLVERR, bus_a.PRDATA, e[32], e[31:0]);
        end
      end
    end
    if (bus_b.PREADY === 1'b1) begin
      checks++;
      if (exp_b_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_pready actual prdata=%h pslverr=%b required=no response",
                 bus_b.PRDATA, bus_b.PSLVERR);
      end else begin
        e = exp_b_q.pop_front();
        if (bus_b.PSLVERR !== e[32] || (e[33] && bus_b.PRDATA !== e[31:0])) begin
          errors++;
          $display("FAIL b_resp addr=%h actual pslverr=%b prdata=%h expected pslverr=%b prdata=%h",
                   e[45:34], bus_b.PSLVERR, bus_b.PRDATA, e[32], e[31:0]);
        end
      end
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_access(input logic [11:0] addr, input bit wr, input logic [31:0] wdata,
                              input logic [3:0] strb, output logic [33:0] resp);
    int kind;
    int idx;
    bit err;
    logic [31:0] data;
    kind = -1;
    idx  = int'(addr) / 4;
    data = 32'h0;
    if (addr[1:0] == 2'b00) begin
      if (addr < 12'h010) kind = 0;
      else if (addr == 12'h100) kind = 1;
      else if (addr == 12'h104) kind = 2;
      else if (addr == 12'h108) kind = 3;
      else if (addr >= 12'h200 && addr < 12'h210) begin
        kind = 4;
        idx  = (int'(addr) - 512) / 4;
      end
    end
    err = (kind < 0) || (wr && (kind == 0 || kind == 4)) || (wr && strb != 4'hF);
    if (!err && !wr) begin
      case (kind)
        0:       data = m_status[idx];
        1:       data = {28'h0, m_changed};
        2:       data = {28'h0, m_mask};
        4:       data = m_shadow[idx];
        default: data = 32'h0;
      endcase
    end
    if (!err && wr) begin
      case (kind)
        1: m_changed = m_changed & ~wdata[3:0];
        2: m_mask = wdata[3:0];
        3: if (wdata[0]) for (int i = 0; i < 4; i++) m_shadow[i] = m_status[i];
        default: ;
      endcase
    end
    resp = {(!wr || err), err, data};
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bus(input bit on_b, input bit sel, input bit en, input logic [11:0] addr,
                           input bit wr, input logic [31:0] wdata, input logic [3:0] strb);
    if (on_b) begin
      bus_b.PSEL = sel; bus_b.PENABLE = en; bus_b.PADDR = addr;
      bus_b.PWRITE = wr; bus_b.PWDATA = wdata; bus_b.PSTRB = strb;
    end else begin
      bus_a.PSEL = sel; bus_a.PENABLE = en; bus_a.PADDR = addr;
      bus_a.PWRITE = wr; bus_a.PWDATA = wdata; bus_a.PSTRB = strb;
    end
  endtask

  // Called just after a rising edge e0; the access is accepted at edge e0+2.
  task automatic apb_xfer(input bit on_b, input logic [11:0] addr, input bit wr,
                          input logic [31:0] wdata, input logic [3:0] strb, input logic [33:0] resp);
    if (on_b) exp_b_q.push_back({addr, resp});
    else      exp_a_q.push_back({addr, resp});
    drive_bus(on_b, 1'b1, 1'b0, addr, wr, wdata, strb);
    @(posedge clk); #1;
    drive_bus(on_b, 1'b1, 1'b1, addr, wr, wdata, strb);
    @(posedge clk); #1;
    drive_bus(on_b, 1'b0, 1'b0, addr, wr, wdata, strb);
    @(posedge clk); #1;
  endtask

  task automatic apb_a(input logic [11:0] addr, input bit wr, input logic [31:0] wdata,
                       input logic [3:0] strb);
    logic [33:0] resp;
    model_access(addr, wr, wdata, strb, resp);
    apb_xfer(1'b0, addr, wr, wdata, strb, resp);
  endtask

  task automatic set_status(input int ch, input logic [31:0] val);
    if (val != m_status[ch]) m_changed[ch] = 1'b1;
    m_status[ch] = val;
    status_a[ch*32 +: 32] = val;
    repeat (SD + 2) @(posedge clk);
    #1;
  endtask

  task automatic check_irq(input string name);
    check32(name, {31'h0, irq_a}, {31'h0, |(m_changed & m_mask)});
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [11:0] addr;
    int op;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    reset_n = 1'b0;
    reset_n_b = 1'b0;
    drive_bus(1'b0, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);
    drive_bus(1'b1, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      m_status[i] = $urandom | 32'h1;
      m_shadow[i] = 32'h0;
      status_a[i*32 +: 32] = m_status[i];
    end
    m_changed = 4'h0;
    m_mask = 4'h0;
    status_b = {10'h3FF, 10'h2AA, 10'h155};

    repeat (3) @(posedge clk);
    #1;
    check32("reset_pready", {31'h0, bus_a.PREADY}, 32'h0);
    check32("reset_pslverr", {31'h0, bus_a.PSLVERR}, 32'h0);
    check32("reset_prdata", bus_a.PRDATA, 32'h0);
    check32("reset_irq", {31'h0, irq_a}, 32'h0);
    reset_n = 1'b1;
    reset_n_b = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Constant inputs across reset: STATUS reads inputs, no change flags.
    for (int i = 0; i < 4; i++) apb_a(12'(4 * i), 1'b0, 32'h0, 4'hF);
    apb_a(12'h100, 1'b0, 32'h0, 4'hF);
    check_irq("irq_after_reset");

    // Step channel 2 from 0 to 0xA5A5_0001 with IRQ_MASK=0x4.
    set_status(2, 32'h0);
    apb_a(12'h100, 1'b1, 32'hF, 4'hF);
    apb_a(12'h104, 1'b1, 32'h4, 4'hF);
    check_irq("irq_before_step");
    status_a[2*32 +: 32] = 32'hA5A5_0001;
    apb_xfer(1'b0, 12'h008, 1'b0, 32'h0, 4'hF, {2'b10, 32'h0});  // accepted one edge before the update
    check32("irq_on_flag_edge", {31'h0, irq_a}, 32'h0);
    @(posedge clk); #1;
    check32("irq_one_after_flag", {31'h0, irq_a}, 32'h1);
    m_status[2] = 32'hA5A5_0001;
    m_changed[2] = 1'b1;
    apb_a(12'h008, 1'b0, 32'h0, 4'hF);
    apb_a(12'h100, 1'b0, 32'h0, 4'hF);

    // W1C on the same edge as a new change of channel 2: the flag stays set.
    status_a[2*32 +: 32] = 32'h1234_5678;
    m_status[2] = 32'h1234_5678;
    @(posedge clk); #1;
    apb_a(12'h100, 1'b1, 32'h4, 4'hF);
    m_changed[2] = 1'b1;
    apb_a(12'h100, 1'b0, 32'h0, 4'hF);
    check_irq("irq_after_collision");
    apb_a(12'h100, 1'b1, 32'h4, 4'hF);
    check_irq("irq_after_clear");
    apb_a(12'h100, 1'b0, 32'h0, 4'hF);

    // Snapshot, then change every input.
    apb_a(12'h108, 1'b1, 32'h1, 4'hF);
    for (int i = 0; i < 4; i++) set_status(i, m_status[i] ^ 32'hFFFF_0F0F);
    for (int i = 0; i < 4; i++) begin
      apb_a(12'(12'h200 + 4 * i), 1'b0, 32'h0, 4'hF);
      apb_a(12'(4 * i), 1'b0, 32'h0, 4'hF);
    end

    // Error cases.
    apb_a(12'h040, 1'b0, 32'h0, 4'hF);
    apb_a(12'h000, 1'b1, 32'h1234, 4'hF);
    apb_a(12'h104, 1'b1, 32'hF, 4'h3);
    apb_a(12'h002, 1'b0, 32'h0, 4'hF);
    apb_a(12'h104, 1'b0, 32'h0, 4'hF);
    apb_a(12'h108, 1'b0, 32'h0, 4'hF);

    // Randomised traffic against the model.
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: set_status($urandom_range(0, 3), $urandom);
        1: begin
          addr = 12'(($urandom_range(0, 1) * 12'h200) + 4 * $urandom_range(0, 3));
          apb_a(addr, 1'b0, 32'h0, 4'hF);
        end
        2: apb_a($urandom_range(0, 1) ? 12'h100 : 12'h104, 1'b0, 32'h0, 4'hF);
        3: apb_a(12'h104, 1'b1, $urandom, 4'hF);
        4: apb_a(12'h100, 1'b1, $urandom, 4'hF);
        5: apb_a(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), $urandom,
                 4'($urandom_range(0, 15)));
        default: apb_a(12'h108, 1'b1, 32'h1, 4'hF);
      endcase
      check_irq("irq_random");
    end

    // Instance b: 3 channels of 10 bits.
    apb_xfer(1'b1, 12'h008, 1'b0, 32'h0, 4'hF, {2'b10, 32'h0000_03FF});
    apb_xfer(1'b1, 12'h000, 1'b0, 32'h0, 4'hF, {2'b10, 32'h0000_0155});
    apb_xfer(1'b1, 12'h00C, 1'b0, 32'h0, 4'hF, {2'b11, 32'h0});
    apb_xfer(1'b1, 12'h100, 1'b0, 32'h0, 4'hF, {2'b10, 32'h0});
    apb_xfer(1'b1, 12'h008, 1'b0, 32'h0, 4'hF, {2'b10, 32'h0000_03FF});

    // Reset asserted during the access phase: no response on the reset edge.
    drive_bus(1'b1, 1'b1, 1'b0, 12'h008, 1'b0, 32'h0, 4'hF);
    @(posedge clk); #1;
    drive_bus(1'b1, 1'b1, 1'b1, 12'h008, 1'b0, 32'h0, 4'hF);
    reset_n_b = 1'b0;
    @(posedge clk); #1;
    check32("b_reset_pready", {31'h0, bus_b.PREADY}, 32'h0);
    check32("b_reset_prdata", bus_b.PRDATA, 32'h0);
    drive_bus(1'b1, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);
    reset_n_b = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    apb_xfer(1'b1, 12'h008, 1'b0, 32'h0, 4'hF, {2'b10, 32'h0000_03FF});
    apb_xfer(1'b1, 12'h100, 1'b0, 32'h0, 4'hF, {2'b10, 32'h0});
    check32("b_irq", {31'h0, irq_b}, 32'h0);

    repeat (5) @(posedge clk);
    #1;
    check32("a_pending_responses", exp_a_q.size(), 32'h0);
    check32("b_pending_responses", exp_b_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
